// File: rtl/mux4_sel_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux4_sel_arb_pkg
//   Shared types and constants for the MUX4 select sequencer.
//   - state_e    : sequencer state (IDLE / BUSY)
//   - SEL_D0..D3 : {SD2,SD1} select codes for the four MUX4 data inputs
//   - CNT_W      : width of the grant hold counter (covers MAX_HOLD up to 255)
//   - onehot4()  : converts an owner index to a one-hot grant vector
// -----------------------------------------------------------------------------
package mux4_sel_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b10;
  localparam logic [1:0] SEL_D3 = 2'b11;

  localparam int CNT_W = 8;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage : mux4_sel_arb_pkg

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
//   Combinational 4-way round-robin picker. The winner is the first set
//   request bit found searching upward from ptr_i, wrapping 3 -> 0.
//   Ports:
//     req_i    [3:0] request vector
//     ptr_i    [1:0] highest-priority index for this search
//     winner_o [1:0] winning index (equals ptr_i when nothing is requested)
//     any_o          at least one request is present
// -----------------------------------------------------------------------------
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] winner_o,
  output logic       any_o
);

  logic [1:0] cand;

  // NOTE: every signal written in always_comb receives a default before any
  // conditional assignment, so no path can leave it unassigned (no latch).
  always_comb begin
    winner_o = ptr_i;
    any_o    = |req_i;
    cand     = ptr_i;
    // Walk offsets from farthest to nearest so the nearest requester,
    // assigned last, wins.
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) winner_o = cand;
    end
  end

endmodule : rr_pick4

// File: rtl/mux4_sel_arb.sv
// -----------------------------------------------------------------------------
// mux4_sel_arb
//   Round-robin select sequencer placed directly in front of a MUX4 cell.
//   Four requesters are arbitrated; the owner's index drives the registered
//   MUX4 selects SD2/SD1. A grant is held while the owner keeps requesting
//   and has not signalled LAST, up to MAX_HOLD consecutive cycles, after
//   which it is force-released and TIMEOUT pulses for one cycle.
//
//   Parameters:
//     MAX_HOLD  max consecutive grant cycles per owner (1..255)
//   Ports:
//     CK       clock, rising edge
//     RSTN     asynchronous active-low reset
//     REQ[3:0] request per MUX4 data input (bit i -> Di)
//     LAST     owner's final beat (only meaningful while VALID=1)
//     LOCK     (only with MUX4_SEL_ARB_LOCK_EN) freezes the hold counter
//     GNT[3:0] one-hot registered grant, 0000 when idle
//     SD1/SD2  MUX4 select LSB/MSB of the owner index
//     VALID    selected Di is presented at Z this cycle
//     TIMEOUT  one-cycle pulse after a MAX_HOLD forced release
//
//   Build option: define MUX4_SEL_ARB_LOCK_EN to add the LOCK input.
// -----------------------------------------------------------------------------
module mux4_sel_arb
  import mux4_sel_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       CK,
  input  logic       RSTN,
  input  logic [3:0] REQ,
  input  logic       LAST,
`ifdef MUX4_SEL_ARB_LOCK_EN
  input  logic       LOCK,
`endif
  output logic [3:0] GNT,
  output logic       SD1,
  output logic       SD2,
  output logic       VALID,
  output logic       TIMEOUT
);

  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(MAX_HOLD - 1);
  // With a 1-cycle hold every grant hits the limit, so TIMEOUT is reported
  // only when the owner actually wanted to continue.
  localparam bit SINGLE_BEAT = (MAX_HOLD == 1);

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       gnt_q,   gnt_d;
  logic             valid_q, valid_d;
  logic             tmo_q,   tmo_d;

  logic       lock_w;
  logic       owner_req;
  logic       cnt_hit;
  logic       release_w;
  logic [1:0] pick_ptr;
  logic [1:0] winner;
  logic       any_req;

`ifdef MUX4_SEL_ARB_LOCK_EN
  assign lock_w = LOCK;
`else
  assign lock_w = 1'b0;
`endif

  assign owner_req = REQ[owner_q];
  assign cnt_hit   = (cnt_q == HOLD_END) && !lock_w;
  assign release_w = (state_q == BUSY) && (!owner_req || LAST || cnt_hit);

  // On release the pointer moves past the owner in the same cycle, so the
  // picker already sees the rotated priority and the handover has no bubble.
  assign pick_ptr = release_w ? (owner_q + 2'd1) : ptr_q;

  rr_pick4 u_pick (
    .req_i    (REQ),
    .ptr_i    (pick_ptr),
    .winner_o (winner),
    .any_o    (any_req)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          owner_d = winner;
          gnt_d   = onehot4(winner);
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end

      BUSY: begin
        if (release_w) begin
          ptr_d = owner_q + 2'd1;
          tmo_d = cnt_hit && (!SINGLE_BEAT || (owner_req && !LAST));
          if (any_req) begin
            owner_d = winner;
            gnt_d   = onehot4(winner);
            cnt_d   = '0;
          end else begin
            // owner_q is left untouched so SD2/SD1 hold while idle.
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
          end
        end else if (!lock_w) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  // The reset is asynchronous so a mid-burst reset drops the grant at once.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      owner_q <= SEL_D0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign GNT   = gnt_q;
  assign SD1   = owner_q[0];
  assign SD2   = owner_q[1];
  assign VALID = valid_q;

`ifdef MUX4_SEL_ARB_LOCK_EN
  assign TIMEOUT = tmo_q & ~LOCK;
`else
  assign TIMEOUT = tmo_q;
`endif

endmodule : mux4_sel_arb

// File: tb/tb_mux4_sel_arb.sv
// -----------------------------------------------------------------------------
// tb_mux4_sel_arb
//   Four sequencers with MAX_HOLD = 4, 2, 1, 3 share one stimulus stream.
//   Each is followed by a per-instance behavioural model that tracks the
//   owner, the number of cycles it has held the grant and the rotating
//   priority pointer. Directed scenarios add fixed expected sequences.
//   Build option: MUX4_SEL_ARB_LOCK_EN adds the LOCK input and its scenario.
// -----------------------------------------------------------------------------
module tb_mux4_sel_arb;

  logic       ck;
  logic       rstn;
  logic [3:0] req;
  logic       last;
  logic       lock;

  logic [3:0] gnt_w   [4];
  logic       sd1_w   [4];
  logic       sd2_w   [4];
  logic       valid_w [4];
  logic       tmo_w   [4];

  int lim [4] = '{4, 2, 1, 3};

  int n_chk;
  int n_pass;

  // ---------------- DUTs ----------------
  mux4_sel_arb #(.MAX_HOLD(4)) u_h4 (
    .CK(ck), .RSTN(rstn), .REQ(req), .LAST(last),
`ifdef MUX4_SEL_ARB_LOCK_EN
    .LOCK(lock),
`endif
    .GNT(gnt_w[0]), .SD1(sd1_w[0]), .SD2(sd2_w[0]), .VALID(valid_w[0]), .TIMEOUT(tmo_w[0])
  );
  mux4_sel_arb #(.MAX_HOLD(2)) u_h2 (
    .CK(ck), .RSTN(rstn), .REQ(req), .LAST(last),
`ifdef MUX4_SEL_ARB_LOCK_EN
    .LOCK(lock),
`endif
    .GNT(gnt_w[1]), .SD1(sd1_w[1]), .SD2(sd2_w[1]), .VALID(valid_w[1]), .TIMEOUT(tmo_w[1])
  );
  mux4_sel_arb #(.MAX_HOLD(1)) u_h1 (
    .CK(ck), .RSTN(rstn), .REQ(req), .LAST(last),
`ifdef MUX4_SEL_ARB_LOCK_EN
    .LOCK(lock),
`endif
    .GNT(gnt_w[2]), .SD1(sd1_w[2]), .SD2(sd2_w[2]), .VALID(valid_w[2]), .TIMEOUT(tmo_w[2])
  );
  mux4_sel_arb #(.MAX_HOLD(3)) u_h3 (
    .CK(ck), .RSTN(rstn), .REQ(req), .LAST(last),
`ifdef MUX4_SEL_ARB_LOCK_EN
    .LOCK(lock),
`endif
    .GNT(gnt_w[3]), .SD1(sd1_w[3]), .SD2(sd2_w[3]), .VALID(valid_w[3]), .TIMEOUT(tmo_w[3])
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  int m_owner [4];   // -1 when idle
  int m_held  [4];   // cycles the current owner has held the grant
  int m_ptr   [4];   // requester searched first at the next arbitration
  int m_sel   [4];   // index currently presented on the selects
  bit m_tmo   [4];

  function automatic int pick(input int ptr, input logic [3:0] r);
    for (int off = 0; off < 4; off++) begin
      int idx;
      idx = (ptr + off) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_owner[i] = -1;
      m_held[i]  = 0;
      m_ptr[i]   = 0;
      m_sel[i]   = 0;
      m_tmo[i]   = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      int w;
      bit hit;
      m_tmo[i] = 1'b0;
      if (m_owner[i] < 0) begin
        w = pick(m_ptr[i], req);
        if (w >= 0) begin
          m_owner[i] = w;
          m_held[i]  = 1;
          m_sel[i]   = w;
        end
      end else begin
        hit = (m_held[i] >= lim[i]) && !lock;
        if (req[m_owner[i]] && !last && !hit) begin
          if (!lock) m_held[i]++;
        end else begin
          m_tmo[i] = hit && (lim[i] > 1 || (req[m_owner[i]] && !last));
          m_ptr[i] = (m_owner[i] + 1) % 4;
          w = pick(m_ptr[i], req);
          if (w >= 0) begin
            m_owner[i] = w;
            m_held[i]  = 1;
            m_sel[i]   = w;
          end else begin
            m_owner[i] = -1;
          end
        end
      end
    end
  endtask

  // {GNT, SD2, SD1, VALID, TIMEOUT}
  function automatic logic [7:0] exp_bus(input int i);
    logic [3:0] g;
    logic [1:0] s;
    g = (m_owner[i] < 0) ? 4'b0000 : 4'(1 << m_owner[i]);
    s = 2'(m_sel[i]);
    return {g, s, (m_owner[i] >= 0), (m_tmo[i] && !lock)};
  endfunction

  function automatic logic [7:0] act_bus(input int i);
    return {gnt_w[i], sd2_w[i], sd1_w[i], valid_w[i], tmo_w[i]};
  endfunction

  // Advance one clock: the model consumes the inputs seen at this edge,
  // then outputs are sampled 1 time unit after it.
  task automatic tick();
    model_step();
    @(posedge ck);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge ck);
    rstn = 1'b0;
    #1;
    model_reset();
    @(negedge ck);
    rstn = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req  = 4'b1111;
    last = 1'b0;
    @(negedge ck);
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (act_bus(i) !== 8'h00)
        $display("FAIL reset_outputs h%0d: got %b want 00000000", lim[i], act_bus(i));
      else n_pass++;
    end
    model_reset();
    @(negedge ck);
    rstn = 1'b1;
    tick();
    n_chk++;
    if ({gnt_w[0], sd2_w[0], sd1_w[0], valid_w[0]} !== 7'b0001_00_1)
      $display("FAIL reset_first_grant: got %b want 0001001",
               {gnt_w[0], sd2_w[0], sd1_w[0], valid_w[0]});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (act_bus(i) !== exp_bus(i))
        $display("FAIL reset_model h%0d: got %b want %b", lim[i], act_bus(i), exp_bus(i));
      else n_pass++;
    end
  endtask

  task automatic test_timeout_handover();
    apply_reset();
    req  = 4'b0110;
    last = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] want;
      tick();
      want = (k <= 4) ? {4'b0010, 2'b01, 1'b1, 1'b0} : {4'b0100, 2'b10, 1'b1, 1'b1};
      n_chk++;
      if (act_bus(0) !== want)
        $display("FAIL timeout_handover cyc%0d: got %b want %b", k, act_bus(0), want);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (act_bus(i) !== exp_bus(i))
          $display("FAIL timeout_model h%0d cyc%0d: got %b want %b", lim[i], k, act_bus(i), exp_bus(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_last_wrap();
    apply_reset();
    req  = 4'b1000;
    last = 1'b0;
    tick();
    req = 4'b1001;
    tick();
    n_chk++;
    if ({gnt_w[0], sd2_w[0], sd1_w[0]} !== 6'b1000_11)
      $display("FAIL last_owner_d3: got %b want 100011", {gnt_w[0], sd2_w[0], sd1_w[0]});
    else n_pass++;
    last = 1'b1;
    tick();
    last = 1'b0;
    n_chk++;
    if (act_bus(0) !== {4'b0001, 2'b00, 1'b1, 1'b0})
      $display("FAIL last_wrap_d0: got %b want 00010010", act_bus(0));
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (act_bus(i) !== exp_bus(i))
        $display("FAIL last_model h%0d: got %b want %b", lim[i], act_bus(i), exp_bus(i));
      else n_pass++;
    end
  endtask

  task automatic test_sole_requester();
    apply_reset();
    req  = 4'b0100;
    last = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_chk++;
      if (act_bus(1) !== {4'b0100, 2'b10, 1'b1, (k == 3 || k == 5)})
        $display("FAIL sole_h2 cyc%0d: got %b want %b", k, act_bus(1),
                 {4'b0100, 2'b10, 1'b1, (k == 3 || k == 5)});
      else n_pass++;
      n_chk++;
      if (tmo_w[2] !== (k >= 2))
        $display("FAIL sole_h1_timeout cyc%0d: got %b want %b", k, tmo_w[2], (k >= 2));
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (act_bus(i) !== exp_bus(i))
          $display("FAIL sole_model h%0d cyc%0d: got %b want %b", lim[i], k, act_bus(i), exp_bus(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset_midburst();
    apply_reset();
    req  = 4'b0010;
    last = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({gnt_w[0], sd2_w[0], sd1_w[0]} !== 6'b0010_01)
      $display("FAIL midburst_owner_d1: got %b want 001001", {gnt_w[0], sd2_w[0], sd1_w[0]});
    else n_pass++;
    #2;
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (act_bus(i) !== 8'h00)
        $display("FAIL midburst_async_clear h%0d: got %b want 00000000", lim[i], act_bus(i));
      else n_pass++;
    end
    model_reset();
    req = 4'b0000;
    @(negedge ck);
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (act_bus(i) !== exp_bus(i))
        $display("FAIL midburst_idle h%0d: got %b want %b", lim[i], act_bus(i), exp_bus(i));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      req  = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
      last = ($urandom_range(0, 3) == 0);
`ifdef MUX4_SEL_ARB_LOCK_EN
      lock = ($urandom_range(0, 4) == 0);
`endif
      tick();
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (act_bus(i) !== exp_bus(i))
          $display("FAIL random h%0d cyc%0d: got %b want %b", lim[i], k, act_bus(i), exp_bus(i));
        else n_pass++;
      end
    end
    req  = 4'b0000;
    last = 1'b0;
    lock = 1'b0;
  endtask

`ifdef MUX4_SEL_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    req  = 4'b0001;
    last = 1'b0;
    lock = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_chk++;
      if ({gnt_w[3], tmo_w[3]} !== 5'b0001_0)
        $display("FAIL lock_hold cyc%0d: got %b want 00010", k, {gnt_w[3], tmo_w[3]});
      else n_pass++;
    end
    lock = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_chk++;
      if (tmo_w[3] !== (k == 3))
        $display("FAIL lock_resume cyc%0d: got %b want %b", k, tmo_w[3], (k == 3));
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (act_bus(i) !== exp_bus(i))
          $display("FAIL lock_model h%0d cyc%0d: got %b want %b", lim[i], k, act_bus(i), exp_bus(i));
        else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rstn   = 1'b0;
    req    = 4'b0000;
    last   = 1'b0;
    lock   = 1'b0;
    model_reset();

    test_reset();
    test_timeout_handover();
    test_last_wrap();
    test_sole_requester();
    test_async_reset_midburst();
`ifdef MUX4_SEL_ARB_LOCK_EN
    test_lock();
`endif
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_mux4_sel_arb
